imem_port_arbiter: RTL and testbench

//  Shares one read-only memory port (mem_interface.ro style) between two requesters:

---
 rtl/imem_port_arbiter_pkg.sv | 15 +
 rtl/imem_port_arbiter_if.sv | 34 +++
 rtl/imem_port_arbiter_rr_arb2.sv | 20 ++
 rtl/imem_port_arbiter.sv | 116 +++++++++++
 tb/tb_imem_port_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_port_arbiter_pkg.sv
// Shared types for the instruction-memory port arbiter.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_FETCH = 1'b0;
    localparam port_id_t PORT_DEBUG = 1'b1;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled.
// slave = arbiter view, master = requesters plus memory view.
interface imem_port_arbiter_if #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16
);
    logic                    req0;
    logic                    req1;
    logic [ADDRESS_SIZE-1:0] addr0;
    logic [ADDRESS_SIZE-1:0] addr1;
    logic                    gnt0;
    logic                    gnt1;
    logic                    rvalid0;
    logic                    rvalid1;
    logic                    rerr0;
    logic                    rerr1;
    logic [0:WORD_SIZE-1]    rdata;
    logic                    mem_enable;
    logic [ADDRESS_SIZE-1:0] mem_address;
    logic [0:WORD_SIZE-1]    mem_data;
    logic                    mem_data_ready;

    modport slave (
        input  req0, req1, addr0, addr1, mem_data, mem_data_ready,
        output gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata,
               mem_enable, mem_address
    );

    modport master (
        output req0, req1, addr0, addr1, mem_data, mem_data_ready,
        input  gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata,
               mem_enable, mem_address
    );
endinterface

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time wins.
module rr_arb2
    import imem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last,
    output port_id_t   grant_id,
    output logic       any
);
    // Winner selection; grant_id is only meaningful while any=1
    always_comb begin
        grant_id = PORT_FETCH;
        if (req == 2'b11)
            grant_id = ~last;
        else if (req[1])
            grant_id = PORT_DEBUG;
    end

    assign any = |req;
endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one read-only memory port between fetch (port 0) and debug (port 1).
// One access outstanding; ENABLE drops for a RELEASE cycle after every access
// so the memory's sticky DATA_READY clears before the next address is served.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst,
    imem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ACCESS  = ACCESS;
    localparam logic [1:0] ST_RELEASE = RELEASE;

    logic [1:0]              state;
    logic [CW-1:0]           cnt;
    port_id_t                last_grant;
    port_id_t                owner;
    port_id_t                pick;
    logic                    any_req;
    logic                    gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, rerr0_q, rerr1_q;
    logic [0:WORD_SIZE-1]    rdata_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic                    ready_ok;
    logic                    timed_out;

    rr_arb2 u_arb (
        .req      ({bus.req1, bus.req0}),
        .last     (last_grant),
        .grant_id (pick),
        .any      (any_req)
    );

    // Ready in the first ACCESS cycle would be the memory's stale valid
    assign ready_ok  = bus.mem_data_ready && (cnt != '0);
    // Abort at the end of the TIMEOUT_CYCLES-th ACCESS cycle
    assign timed_out = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Access sequencer: grant, wait for ready or timeout, release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= PORT_DEBUG;
            owner      <= PORT_FETCH;
            addr_q     <= '0;
            rdata_q    <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rerr0_q    <= 1'b0;
            rerr1_q    <= 1'b0;
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rerr0_q   <= 1'b0;
            rerr1_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner      <= pick;
                        last_grant <= pick;
                        addr_q     <= (pick == PORT_DEBUG) ? bus.addr1 : bus.addr0;
                        gnt0_q     <= (pick == PORT_FETCH);
                        gnt1_q     <= (pick == PORT_DEBUG);
                        cnt        <= '0;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (ready_ok) begin
                        rdata_q   <= bus.mem_data;
                        rvalid0_q <= (owner == PORT_FETCH);
                        rvalid1_q <= (owner == PORT_DEBUG);
                        state     <= ST_RELEASE;
                    end else if (timed_out) begin
                        rdata_q   <= '0;
                        rvalid0_q <= (owner == PORT_FETCH);
                        rvalid1_q <= (owner == PORT_DEBUG);
                        rerr0_q   <= (owner == PORT_FETCH);
                        rerr1_q   <= (owner == PORT_DEBUG);
                        state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_enable  = (state == ST_ACCESS);
    assign bus.mem_address = addr_q;
    assign bus.rdata       = rdata_q;
    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.rerr0       = rerr0_q;
    assign bus.rerr1       = rerr1_q;

    a_one_gnt: assert property (@(posedge clk) disable iff (!rst) !(gnt0_q && gnt1_q));
    a_one_rvalid: assert property (@(posedge clk) disable iff (!rst) !(rvalid0_q && rvalid1_q));
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a 1-cycle sticky-ready ROM model
// and a scoreboard of expected read responses.
module tb_imem_port_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hold_ready  = 1'b0;
    logic force_ready = 1'b0;
    logic        rdy_q = 1'b0;
    logic [31:0] mem_q = '0;
    int n_asrt = 0;
    int n_fail = 0;
    exp_t sb[$];

    imem_port_arbiter_if #(.WORD_SIZE(32), .ADDRESS_SIZE(16)) bus ();

    imem_port_arbiter #(.WORD_SIZE(32), .ADDRESS_SIZE(16), .TIMEOUT_CYCLES(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return 32'h2001_0001 + {16'h0, a};
    endfunction

    // ROM: ready one cycle after ENABLE, sticky while ENABLE stays high
    always @(posedge clk) begin
        if (bus.mem_enable) begin
            rdy_q <= 1'b1;
            mem_q <= rom_word(bus.mem_address);
        end else begin
            rdy_q <= 1'b0;
        end
    end

    assign bus.mem_data_ready = force_ready | (rdy_q & ~hold_ready);
    assign bus.mem_data = force_ready ? rom_word(bus.mem_address) :
                          (bus.mem_data_ready ? mem_q : 32'hDEAD_BEEF);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_gnt(input logic exp_port, input string tag, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(bus.gnt0 || bus.gnt1) && cyc < 40);
        check({tag, " gnt"}, 64'({bus.gnt0, bus.gnt1}), exp_port ? 64'h1 : 64'h2);
    endtask

    task automatic wait_rv(input logic exp_port, input string tag, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(bus.rvalid0 || bus.rvalid1) && cyc < 40);
        check({tag, " rvalid"}, 64'({bus.rvalid0, bus.rvalid1}), exp_port ? 64'h1 : 64'h2);
    endtask

    // Scoreboard: every rvalid pops and checks the oldest expected response
    always @(negedge clk) begin
        if (rst && (bus.rvalid0 || bus.rvalid1)) begin
            if (sb.size() == 0) begin
                check("unexpected rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb port", 64'({bus.rvalid0, bus.rvalid1}), e.port ? 64'h1 : 64'h2);
                check("sb rdata", 64'(bus.rdata), 64'(e.data));
                check("sb rerr", 64'(e.port ? bus.rerr1 : bus.rerr0), 64'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.addr0 = '0;  bus.addr1 = '0;

        // Reset state
        tick(); tick();
        check("rst gnt", 64'({bus.gnt0, bus.gnt1}), 64'h0);
        check("rst rvalid", 64'({bus.rvalid0, bus.rvalid1, bus.rerr0, bus.rerr1}), 64'h0);
        check("rst mem_enable", 64'(bus.mem_enable), 64'h0);
        check("rst mem_address", 64'(bus.mem_address), 64'h0);
        check("rst rdata", 64'(bus.rdata), 64'h0);
        rst = 1'b1;
        tick();

        // Both requesting from reset: port 0 first, then strict alternation
        bus.addr0 = 16'd1; bus.addr1 = 16'd2;
        bus.req0 = 1'b1;   bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++)
            sb.push_back('{port: k[0], data: rom_word(k[0] ? 16'd2 : 16'd1), err: 1'b0});
        for (int k = 0; k < 4; k++) begin
            wait_gnt(k[0], "alt", c);
            if (k > 0) check("alt gap", 64'(c), 64'd4);
        end
        wait_rv(1'b1, "alt last", c);
        check("alt release enable", 64'(bus.mem_enable), 64'h0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick(); tick();

        // Single fetch request: gnt one cycle after, rvalid two cycles after gnt
        bus.addr0 = 16'h0004; bus.req0 = 1'b1;
        sb.push_back('{port: 1'b0, data: 32'h2001_0005, err: 1'b0});
        wait_gnt(1'b0, "single", c);
        check("single gnt latency", 64'(c), 64'd1);
        check("single mem_address", 64'(bus.mem_address), 64'h4);
        check("single enable", 64'(bus.mem_enable), 64'h1);
        wait_rv(1'b0, "single", c);
        check("single rv latency", 64'(c), 64'd2);
        bus.req0 = 1'b0;
        tick();

        // Back-to-back fetches: second must return word7, not the stale word3
        bus.addr0 = 16'd3; bus.req0 = 1'b1;
        sb.push_back('{port: 1'b0, data: rom_word(16'd3), err: 1'b0});
        sb.push_back('{port: 1'b0, data: rom_word(16'd7), err: 1'b0});
        wait_rv(1'b0, "b2b first", c);
        bus.addr0 = 16'd7;
        wait_gnt(1'b0, "b2b second", c);
        check("b2b second address", 64'(bus.mem_address), 64'h7);
        wait_rv(1'b0, "b2b second", c);
        bus.req0 = 1'b0;
        tick();

        // Dead memory: abort after 15 ACCESS cycles with rerr, then normal service
        hold_ready = 1'b1;
        bus.addr0 = 16'd5; bus.req0 = 1'b1;
        sb.push_back('{port: 1'b0, data: 32'h0, err: 1'b1});
        wait_gnt(1'b0, "timeout", c);
        wait_rv(1'b0, "timeout", c);
        check("timeout cycles", 64'(c), 64'd15);
        hold_ready = 1'b0;
        bus.addr0 = 16'd6;
        sb.push_back('{port: 1'b0, data: rom_word(16'd6), err: 1'b0});
        wait_rv(1'b0, "after timeout", c);
        bus.req0 = 1'b0;
        tick();

        // Reset in the middle of an access
        bus.addr0 = 16'd8; bus.req0 = 1'b1;
        wait_gnt(1'b0, "mid rst", c);
        #2 rst = 1'b0;
        #1;
        check("mid rst enable", 64'(bus.mem_enable), 64'h0);
        check("mid rst gnt", 64'({bus.gnt0, bus.gnt1}), 64'h0);
        check("mid rst rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'h0);
        bus.req0 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        check("mid rst no response", 64'(sb.size()), 64'h0);
        bus.addr0 = 16'd9; bus.req0 = 1'b1;
        sb.push_back('{port: 1'b0, data: rom_word(16'd9), err: 1'b0});
        wait_rv(1'b0, "after rst", c);
        bus.req0 = 1'b0;
        tick();

        // Debug requester drops req during ACCESS: response still delivered once
        bus.addr1 = 16'h000A; bus.req1 = 1'b1;
        sb.push_back('{port: 1'b1, data: rom_word(16'h000A), err: 1'b0});
        wait_gnt(1'b1, "drop", c);
        tick();
        bus.req1 = 1'b0;
        wait_rv(1'b1, "drop", c);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drop idle", 64'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_enable}), 64'h0);
        end

        // Memory claiming ready in the first ACCESS cycle is ignored
        force_ready = 1'b1;
        bus.addr0 = 16'h000B; bus.req0 = 1'b1;
        sb.push_back('{port: 1'b0, data: rom_word(16'h000B), err: 1'b0});
        wait_gnt(1'b0, "stale ready", c);
        wait_rv(1'b0, "stale ready", c);
        check("stale ready latency", 64'(c), 64'd2);
        bus.req0 = 1'b0;
        force_ready = 1'b0;
        tick(); tick();

        check("scoreboard drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
